// File: rtl/dm_responder.sv
// Fixed-latency data-memory responder for the CPU load/store port.
// It accepts one word request, waits LATENCY cycles, then gives a one-cycle ack with read data or an error.
module dm_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int          AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LAT  = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          l_we;
    logic [3:0]    l_be;
    logic [31:0]   l_addr;
    logic [31:0]   l_wdata;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   off;
    logic          bad;
    logic [AW-1:0] idx;
    logic [31:0]   cur;
    logic [31:0]   merged;
    logic          commit;

    // The PC feeds only the simulation write log, which the hardware does not implement.
    logic unused_pc;
    assign unused_pc = ^pc;

    assign busy   = (state != IDLE);
    assign commit = (state == WAIT) && (cnt == 4'd1);

    // Everything that commits is derived from the latched request, never from the live bus.
    always_comb begin
        off    = l_addr - BASE_ADDR;
        bad    = (l_addr[1:0] != 2'b00) || (l_addr < BASE_ADDR) || ({1'b0, off} >= SPAN);
        idx    = off[AW+1:2];
        cur    = mem[idx];
        merged = cur;
        for (int i = 0; i < 4; i++) begin
            if (l_be[i]) merged[8*i +: 8] = l_wdata[8*i +: 8];
        end
    end

    // NOTE: the storage sits on the async reset because a reset must leave every word zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) mem[i] <= '0;
        end else if (commit && l_we && !bad && (l_be != 4'b0000)) begin
            mem[idx] <= merged;
        end
    end

    // NOTE: all state uses non-blocking assignments, so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            l_we    <= 1'b0;
            l_be    <= '0;
            l_addr  <= '0;
            l_wdata <= '0;
            ack     <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            ack   <= 1'b0;
            rdata <= '0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        l_we    <= we;
                        l_be    <= be;
                        l_addr  <= addr;
                        l_wdata <= wdata;
                        cnt     <= LAT;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        ack   <= 1'b1;
                        err   <= bad;
                        rdata <= (!bad && !l_we) ? cur : 32'h0;
                    end
                end
                RESP: begin
                    // The initiator still holds its old req here, so it is ignored.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: latency, byte merge, error cases, reset abort and back-to-back requests.
module tb_dm_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, pc;
    logic        busy, ack, err;
    logic [31:0] rdata;

    logic        req1, we1;
    logic [3:0]  be1;
    logic [31:0] addr1, wdata1, pc1;
    logic        busy1, ack1, err1;
    logic [31:0] rdata1;

    int          checks = 0;
    int          passed = 0;
    logic [31:0] rd;
    logic        e;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .pc(pc), .busy(busy), .ack(ack), .rdata(rdata), .err(err)
    );

    dm_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .we(we1), .be(be1), .addr(addr1),
        .wdata(wdata1), .pc(pc1), .busy(busy1), .ack(ack1), .rdata(rdata1), .err(err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // One full transaction on the LATENCY=2 instance; returns the data and error seen with ack.
    task automatic txn(input string tag, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic er);
        int lat;
        lat = -1;
        r   = '0;
        er  = 1'b0;
        @(posedge clk);
        #1;
        req = 1'b1; we = w; be = b; addr = a; wdata = d; pc = 32'h0000_0400 + a;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 2) check({tag, "_busy"}, 32'(busy), 32'd1);
            if (ack) begin
                lat = i - 2;
                r   = rdata;
                er  = err;
                break;
            end
        end
        check({tag, "_latency"}, lat, LAT);
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
        @(negedge clk);
        check({tag, "_pulse"}, 32'(ack), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acks, first, prev, cnt, gap_bad, wide;
        logic last;

        reset = 1'b1;
        req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0; pc = '0;
        req1 = 1'b0; we1 = 1'b0; be1 = '0; addr1 = '0; wdata1 = '0; pc1 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        repeat (5) @(negedge clk);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_ack",   32'(ack),   32'd0);
        check("rst_err",   32'(err),   32'd0);
        check("rst_rdata", rdata,      32'h0);
        check("rst_busy1", 32'(busy1), 32'd0);

        txn("ld0", 1'b0, 4'h0, 32'h0, 32'h0, rd, e);
        check("ld0_rdata", rd, 32'h0);
        check("ld0_err", 32'(e), 32'd0);

        txn("st10", 1'b1, 4'hF, 32'h10, 32'h1122_3344, rd, e);
        check("st10_err", 32'(e), 32'd0);
        check("st10_rdata", rd, 32'h0);
        txn("ld10", 1'b0, 4'h0, 32'h10, 32'h0, rd, e);
        check("ld10_rdata", rd, 32'h1122_3344);

        txn("st10_b1", 1'b1, 4'b0010, 32'h10, 32'hAABB_CCDD, rd, e);
        txn("ld10_b1", 1'b0, 4'hF, 32'h10, 32'h0, rd, e);
        check("ld10_b1_rdata", rd, 32'h1122_CC44);

        txn("st_be0", 1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF, rd, e);
        check("st_be0_err", 32'(e), 32'd0);
        txn("ld_be0", 1'b0, 4'h0, 32'h10, 32'h0, rd, e);
        check("ld_be0_rdata", rd, 32'h1122_CC44);

        txn("st_top", 1'b1, 4'hF, 32'hFFC, 32'hDEAD_BEEF, rd, e);
        check("st_top_err", 32'(e), 32'd0);
        txn("ld_top", 1'b0, 4'h0, 32'hFFC, 32'h0, rd, e);
        check("ld_top_rdata", rd, 32'hDEAD_BEEF);

        txn("st0", 1'b1, 4'hF, 32'h0, 32'h0BAD_F00D, rd, e);
        txn("ld_mis", 1'b0, 4'h0, 32'h3, 32'h0, rd, e);
        check("ld_mis_err", 32'(e), 32'd1);
        check("ld_mis_rdata", rd, 32'h0);
        txn("st_oor", 1'b1, 4'hF, 32'h1000, 32'hFFFF_FFFF, rd, e);
        check("st_oor_err", 32'(e), 32'd1);
        txn("st_mis", 1'b1, 4'hF, 32'h2, 32'h1234_5678, rd, e);
        check("st_mis_err", 32'(e), 32'd1);
        txn("ld_oor", 1'b0, 4'h0, 32'h1000, 32'h0, rd, e);
        check("ld_oor_err", 32'(e), 32'd1);
        check("ld_oor_rdata", rd, 32'h0);
        txn("ld0_keep", 1'b0, 4'h0, 32'h0, 32'h0, rd, e);
        check("ld0_keep_rdata", rd, 32'h0BAD_F00D);

        // Reset one cycle after accepting a store: it must never commit or ack.
        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h20; wdata = 32'h55AA_55AA;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack) acks++;
        end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack) acks++;
        end
        check("abort_noack", acks, 0);
        txn("ld20", 1'b0, 4'h0, 32'h20, 32'h0, rd, e);
        check("ld20_rdata", rd, 32'h0);
        txn("ld10_clr", 1'b0, 4'h0, 32'h10, 32'h0, rd, e);
        check("ld10_clr_rdata", rd, 32'h0);
        txn("ld_top_clr", 1'b0, 4'h0, 32'hFFC, 32'h0, rd, e);
        check("ld_top_clr_rdata", rd, 32'h0);

        // LATENCY=1 with req held high: one ack every third cycle, each a single cycle wide.
        @(posedge clk);
        #1 req1 = 1'b1;
        first = -1; prev = -1; cnt = 0; gap_bad = 0; wide = 0; last = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (ack1) begin
                if (last) wide++;
                if (prev >= 0 && (i - prev) != 3) gap_bad++;
                if (first < 0) first = i;
                prev = i;
                cnt++;
            end
            last = ack1;
        end
        #1 req1 = 1'b0;
        check("lat1_first", first, 3);
        check("lat1_count", cnt, 10);
        check("lat1_gap", gap_bad, 0);
        check("lat1_width", wide, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
